// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Legal range of the memory read latency and the counter width covering it.
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 7;
  localparam int LAT_W        = 3;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker between fetch and data requests.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_owner_i,
  output logic   valid_o,
  output owner_e winner_o
);

  // A lone requester wins; on a conflict the side not served last goes first.
  always_comb begin
    valid_o  = i_req_i | d_req_i;
    winner_o = OWN_I;
    if (d_req_i && (!i_req_i || last_owner_i == OWN_I)) begin
      winner_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto one single-port memory,
// sequencing the fixed read latency and routing responses to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              I_Req,
  input  logic [ADDR_W-1:0] I_Addr,
  output logic              I_Gnt,
  output logic              I_RValid,
  output logic [DATA_W-1:0] I_RData,
  input  logic              D_Req,
  input  logic              D_We,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  output logic              D_Gnt,
  output logic              D_Done,
  output logic [DATA_W-1:0] D_RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_WrEn,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Busy,
  output logic              Owner
);

  // Counter reload value: a read spends READ_LAT cycles in ACCESS.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              pick_valid;
  owner_e            pick_winner;
  logic              first_access;

  // owner_q doubles as last_owner: it is updated on every grant.
  mem_arb_rr u_rr (
    .i_req_i      (I_Req),
    .d_req_i      (D_Req),
    .last_owner_i (owner_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  // State and latched access registers; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic: sample requests in IDLE, count latency in ACCESS.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          owner_d = pick_winner;
          lat_d   = LAT_LOAD;
          if (pick_winner == OWN_D) begin
            addr_d  = D_Addr;
            we_d    = D_We;
            wdata_d = D_WData;
          end else begin
            addr_d  = I_Addr;
            we_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else if (lat_q == '0) begin
          rdata_d = Mem_RData;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the counter still holds its reload value in the first
  // ACCESS cycle, which marks the grant cycle for reads and stores alike.
  always_comb begin
    first_access = (state_q == ACCESS) && (lat_q == LAT_LOAD);
    I_Gnt        = first_access && (owner_q == OWN_I);
    D_Gnt        = first_access && (owner_q == OWN_D);
    I_RValid     = (state_q == RESP) && (owner_q == OWN_I);
    D_Done       = (state_q == RESP) && (owner_q == OWN_D);
    Mem_WrEn     = (state_q == ACCESS) && we_q;
    Busy         = (state_q != IDLE);
    Owner        = owner_q;
    Mem_Addr     = addr_q;
    Mem_WData    = wdata_q;
    I_RData      = rdata_q;
    D_RData      = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// sequences, a latency sweep and a randomized run against a transaction model.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        Clk;
  logic        Reset_n;
  logic        I_Req, I_Gnt, I_RValid;
  logic [31:0] I_Addr, I_RData;
  logic        D_Req, D_We, D_Gnt, D_Done;
  logic [31:0] D_Addr, D_WData, D_RData;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
  logic        Mem_WrEn, Busy, Owner;
  logic [31:0] mem_rd;
  int          cyc;
  int          n_chk, n_err;

  assign Mem_RData = mem_rd;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(L)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Gnt(I_Gnt), .I_RValid(I_RValid), .I_RData(I_RData),
    .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_WData(D_WData),
    .D_Gnt(D_Gnt), .D_Done(D_Done), .D_RData(D_RData),
    .Mem_Addr(Mem_Addr), .Mem_WrEn(Mem_WrEn), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData),
    .Busy(Busy), .Owner(Owner)
  );

  // Latency sweep instances (READ_LAT 1 and 7); memory data encodes the cycle.
  logic        sw_req;
  logic [31:0] sw_addr;
  logic        sw_igt [2];
  logic        sw_irv [2];
  logic [31:0] sw_ird [2];
  logic        sw_dgt [2];
  logic        sw_ddn [2];
  logic [31:0] sw_drd [2];
  logic [31:0] sw_maddr [2];
  logic [31:0] sw_mwd [2];
  logic        sw_wren [2];
  logic        sw_busy [2];
  logic        sw_own [2];

  for (genvar g = 0; g < 2; g++) begin : g_sw
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT((g == 0) ? 1 : 7)) u_sw (
      .Clk(Clk), .Reset_n(Reset_n),
      .I_Req(sw_req), .I_Addr(sw_addr), .I_Gnt(sw_igt[g]), .I_RValid(sw_irv[g]), .I_RData(sw_ird[g]),
      .D_Req(1'b0), .D_We(1'b0), .D_Addr(32'h0), .D_WData(32'h0),
      .D_Gnt(sw_dgt[g]), .D_Done(sw_ddn[g]), .D_RData(sw_drd[g]),
      .Mem_Addr(sw_maddr[g]), .Mem_WrEn(sw_wren[g]), .Mem_WData(sw_mwd[g]),
      .Mem_RData({sw_maddr[g][15:0], cyc[15:0]}),
      .Busy(sw_busy[g]), .Owner(sw_own[g])
    );
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{I_Gnt, I_RValid, I_RData, D_Gnt, D_Done, D_RData,
             Mem_Addr, Mem_WrEn, Mem_WData, Busy, Owner};
  endfunction

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrd;
    logic [6:0]  ctrl;   // {I_Gnt, I_RValid, D_Gnt, D_Done, Mem_WrEn, Busy, Owner}
    logic        chk_a;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        chk_d;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic ireq, input logic [31:0] ia, input logic dreq, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                     input logic [6:0] ctrl, input logic ca, input logic [31:0] ma,
                     input logic [31:0] mwd, input logic cd, input logic [31:0] rd);
    vec_t v;
    v.ireq = ireq; v.iaddr = ia; v.dreq = dreq; v.dwe = dwe; v.daddr = da; v.dwdata = dwd;
    v.mrd = mrd; v.ctrl = ctrl; v.chk_a = ca; v.maddr = ma; v.mwdata = mwd;
    v.chk_d = cd; v.rdata = rd;
    tv.push_back(v);
  endtask

  // Randomized-phase model state (transaction level).
  bit          m_busy_tx;
  int          m_t0, m_end;
  bit          m_own, m_we, m_last;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial begin
    bit          found;
    int          gk [2];
    int          vk [2];
    int          vcnt [2];
    logic [31:0] vd [2];
    int          c0;
    logic [1:0]  exp_g;
    logic [15:0] tcyc;

    n_chk = 0; n_err = 0;
    Reset_n = 1'b0;
    I_Req = 0; I_Addr = 0; D_Req = 0; D_We = 0; D_Addr = 0; D_WData = 0; mem_rd = 0;
    sw_req = 0; sw_addr = 0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // ---------------- directed vector table (READ_LAT = 2) ----------------
    add(1, 32'h40, 1, 0, 32'h200, 0,  32'h0,        7'b0000000, 0, 0,       0,            0, 0);
    add(1, 32'h40, 0, 0, 0, 0,        32'h99999999, 7'b0010011, 1, 32'h200, 0,            0, 0);
    add(1, 32'h40, 0, 0, 0, 0,        32'h11112222, 7'b0000011, 1, 32'h200, 0,            0, 0);
    add(1, 32'h40, 0, 0, 0, 0,        32'h77777777, 7'b0001011, 1, 32'h200, 0,            1, 32'h11112222);
    add(1, 32'h40, 0, 0, 0, 0,        32'h0,        7'b0000001, 1, 32'h200, 0,            0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h12345678, 7'b1000010, 1, 32'h40,  0,            0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h8C220004, 7'b0000010, 1, 32'h40,  0,            0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h0,        7'b0100010, 1, 32'h40,  0,            1, 32'h8C220004);
    add(0, 0,      1, 1, 32'h100, 32'hDEADBEEF, 0, 7'b0000000, 1, 32'h40,  0,            0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h0,        7'b0010111, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h0,        7'b0001011, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    add(1, 32'h44, 1, 0, 32'h204, 0,  32'h0,        7'b0000001, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    add(0, 0,      1, 0, 32'h204, 0,  32'h0,        7'b1000010, 1, 32'h44,  32'hDEADBEEF, 0, 0);
    add(0, 0,      1, 0, 32'h204, 0,  32'hCAFEF00D, 7'b0000010, 1, 32'h44,  32'hDEADBEEF, 0, 0);
    add(0, 0,      1, 0, 32'h204, 0,  32'h0,        7'b0100010, 1, 32'h44,  32'hDEADBEEF, 1, 32'hCAFEF00D);
    add(0, 0,      1, 0, 32'h204, 0,  32'h0,        7'b0000000, 1, 32'h44,  32'hDEADBEEF, 0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h0,        7'b0010011, 1, 32'h204, 0,            0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h0BADF00D, 7'b0000011, 1, 32'h204, 0,            0, 0);
    add(0, 0,      0, 0, 0, 0,        32'h0,        7'b0001011, 1, 32'h204, 0,            1, 32'h0BADF00D);
    add(0, 0,      0, 0, 0, 0,        32'h0,        7'b0000001, 1, 32'h204, 0,            0, 0);

    foreach (tv[i]) begin
      chk($sformatf("vec%0d_ctrl", i),
          {25'd0, I_Gnt, I_RValid, D_Gnt, D_Done, Mem_WrEn, Busy, Owner}, {25'd0, tv[i].ctrl});
      if (tv[i].chk_a) begin
        chk($sformatf("vec%0d_maddr", i), Mem_Addr, tv[i].maddr);
        chk($sformatf("vec%0d_mwdata", i), Mem_WData, tv[i].mwdata);
      end
      if (tv[i].chk_d) begin
        if (tv[i].ctrl[5]) chk($sformatf("vec%0d_irdata", i), I_RData, tv[i].rdata);
        else               chk($sformatf("vec%0d_drdata", i), D_RData, tv[i].rdata);
      end
      I_Req = tv[i].ireq; I_Addr = tv[i].iaddr;
      D_Req = tv[i].dreq; D_We = tv[i].dwe; D_Addr = tv[i].daddr; D_WData = tv[i].dwdata;
      mem_rd = tv[i].mrd;
      @(negedge Clk);
    end

    // ---------------- both requests held: grants alternate ----------------
    I_Req = 1; I_Addr = 32'h80; D_Req = 1; D_We = 0; D_Addr = 32'h280; D_WData = 0;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b10 : 2'b01;
      found = 0;
      for (int w = 0; w < 12 && !found; w++) begin
        @(negedge Clk);
        if (I_Gnt || D_Gnt) found = 1;
      end
      chk($sformatf("alt_grant%0d", n), {30'd0, I_Gnt, D_Gnt}, {30'd0, exp_g});
    end
    I_Req = 0; D_Req = 0;
    found = 0;
    for (int w = 0; w < 12 && !found; w++) begin
      @(negedge Clk);
      if (!Busy) found = 1;
    end
    chk("alt_back_idle", {31'd0, Busy}, 32'd0);

    // ---------------- latency sweep READ_LAT = 1 and 7 ----------------
    sw_req = 1; sw_addr = 32'h1234_0ABC; c0 = cyc;
    for (int g = 0; g < 2; g++) begin gk[g] = -1; vk[g] = -1; vcnt[g] = 0; vd[g] = 0; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      for (int g = 0; g < 2; g++) begin
        if (sw_igt[g]) gk[g] = k;
        if (sw_irv[g]) begin vk[g] = k; vcnt[g]++; vd[g] = sw_ird[g]; end
      end
      if (k == 1) sw_req = 0;
    end
    for (int g = 0; g < 2; g++) begin
      int lat;
      lat = (g == 0) ? 1 : 7;
      tcyc = 16'(c0 + lat);
      chk($sformatf("sweep_L%0d_gnt_cycle", lat), gk[g], 32'd1);
      chk($sformatf("sweep_L%0d_valid_cycle", lat), vk[g], 32'(1 + lat));
      chk($sformatf("sweep_L%0d_valid_count", lat), vcnt[g], 32'd1);
      chk($sformatf("sweep_L%0d_rdata", lat), vd[g], {16'h0ABC, tcyc});
    end

    // ---------------- reset in the second ACCESS cycle of a load ----------------
    D_Req = 1; D_We = 0; D_Addr = 32'h300; D_WData = 32'h5555AAAA;
    @(negedge Clk);
    chk("abort_pre_dgnt", {31'd0, D_Gnt}, 32'd1);
    D_Req = 0;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk("abort_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
    I_Req = 1; D_Req = 1; I_Addr = 32'h48; D_Addr = 32'h308;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk($sformatf("abort_no_resp%0d", k), {30'd0, I_RValid, D_Done}, 32'd0);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_reset_winner", {30'd0, I_Gnt, D_Gnt}, 32'b01);
    I_Req = 0; D_Req = 0;
    found = 0;
    for (int w = 0; w < 12 && !found; w++) begin
      @(negedge Clk);
      if (!Busy) found = 1;
    end
    chk("post_reset_idle", {31'd0, Busy}, 32'd0);

    // ---------------- randomized run against the transaction model ----------------
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_busy_tx = 0; m_t0 = 0; m_end = 0; m_own = 0; m_we = 0; m_last = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0;
    for (int n = 0; n < 3000; n++) begin
      int  c, k;
      bit  busy, gnt, vld, win_d;
      c    = cyc;
      busy = m_busy_tx && (c >= m_t0 + 1) && (c <= m_end);
      k    = c - m_t0;
      gnt  = busy && (k == 1);
      vld  = busy && (c == m_end);
      chk($sformatf("rnd_ctrl@%0d", c),
          {25'd0, I_Gnt, I_RValid, D_Gnt, D_Done, Mem_WrEn, Busy, Owner},
          {25'd0, gnt && !m_own, vld && !m_own, gnt && m_own, vld && m_own,
           gnt && m_we, busy, m_own});
      chk($sformatf("rnd_maddr@%0d", c), Mem_Addr, m_addr);
      chk($sformatf("rnd_mwdata@%0d", c), Mem_WData, m_wdata);
      chk($sformatf("rnd_rdata@%0d", c), vld && m_own ? D_RData : I_RData, m_rdata);

      // Requesters: drop on grant, raise new requests at random when not in flight.
      if (gnt && !m_own) I_Req = 0;
      if (gnt &&  m_own) D_Req = 0;
      if (!I_Req && !(busy && !m_own) && $urandom_range(0, 3) == 0) begin
        I_Req = 1; I_Addr = $urandom;
      end
      if (!D_Req && !(busy && m_own) && $urandom_range(0, 3) == 0) begin
        D_Req = 1; D_We = 1'($urandom_range(0, 1)); D_Addr = $urandom; D_WData = $urandom;
      end
      mem_rd = $urandom;

      // Model update for the edge closing cycle c.
      if (busy && !m_we && c == m_t0 + L) m_rdata = mem_rd;
      if (!busy && (I_Req || D_Req)) begin
        win_d     = D_Req && (!I_Req || !m_last);
        m_busy_tx = 1;
        m_t0      = c;
        m_own     = win_d;
        m_last    = win_d;
        if (win_d) begin
          m_we = D_We; m_addr = D_Addr; m_wdata = D_WData;
        end else begin
          m_we = 0; m_addr = I_Addr;
        end
        m_end = m_we ? c + 2 : c + 1 + L;
      end
      @(negedge Clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between the instruction-fetch requester and the load/store requester of the multicycle CPU.
- Takes over the memory-wait sequencing that the control unit currently performs with fixed delay states.
- Serialises accesses and honours the fixed memory read latency.
- Returns read data or a write acknowledge to the requester that owns the access.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
READ_LAT, 2, cycles from Mem_Addr first presented to Mem_RData valid (legal 1..7)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
I_Req  in  1  fetch read request (level)
I_Addr  in  ADDR_W  fetch address
I_Gnt  out  1  one-cycle pulse: fetch request accepted
I_RValid  out  1  one-cycle pulse: I_RData valid
I_RData  out  DATA_W  fetch read data
D_Req  in  1  data request (level)
D_We  in  1  1 = store, 0 = load
D_Addr  in  ADDR_W  data address
D_WData  in  DATA_W  store data
D_Gnt  out  1  one-cycle pulse: data request accepted
D_Done  out  1  one-cycle pulse: load data valid or store committed
D_RData  out  DATA_W  load data
Mem_Addr  out  ADDR_W  memory address
Mem_WrEn  out  1  memory write enable
Mem_WData  out  DATA_W  memory write data
Mem_RData  in  DATA_W  memory read data
Busy  out  1  state != IDLE
Owner  out  1  0 = fetch, 1 = data; owner of the current or last access

Behaviour:
- Reset:
  - Reset_n low forces IDLE asynchronously, aborting any access.
  - All outputs go to 0, including Mem_WrEn, in the same instant. Pending read data is discarded.
  - last_owner resets to fetch.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Req lines are sampled only in IDLE.
  - On a clock edge with any Req high, latch the winner's address, we and wdata (fetch: we=0). Set Owner, load lat_cnt, go to ACCESS.
  - With no Req high, stay in IDLE.
- Arbitration: 2-way round-robin.
  - Sole requester wins.
  - When both request, the winner is the one that is not last_owner.
  - last_owner updates on every grant. The first conflict after reset goes to data.
- ACCESS:
  - The owner's Gnt is high in the first ACCESS cycle only.
  - Mem_Addr and Mem_WData drive the latched values.
  - Store: Mem_WrEn=1 for exactly that one cycle, then go to RESP.
  - Load/fetch: Mem_WrEn=0; stay READ_LAT cycles, with lat_cnt counting READ_LAT-1 down to 0.
  - At the edge leaving ACCESS with lat_cnt=0, capture Mem_RData into the rdata register, then go to RESP.
- RESP:
  - Owner's RValid/Done high for one cycle.
  - I_RData/D_RData both show the rdata register and are meaningful only with their own valid.
  - Next state is IDLE unconditionally.
- Latency, counted from the request-sample edge (cycle 0 = IDLE with Req):
  - Read: Gnt in cycle 1, valid in cycle 1+READ_LAT, IDLE in cycle 2+READ_LAT.
  - Store: Gnt and WrEn in cycle 1, Done in cycle 2, IDLE in cycle 3.
- Requester contract:
  - Req and payload are held stable until Gnt.
  - Req must drop no later than the cycle its RValid/Done is high. A Req still high when the arbiter is back in IDLE is a new transfer.
- Non-owner Req changing during ACCESS/RESP is ignored.
- Mem_Addr/Mem_WData hold their last values in IDLE and RESP. Mem_WrEn is 0 outside a store's ACCESS cycle.
- rdata register and Owner hold until the next capture or grant.
- Addresses are passed unchanged; no alignment check.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {OWN_I=0, OWN_D=1};
  - READ_LAT range constant.
- One sub-module, mem_arb_rr: combinational 2-way round-robin picker.
  - Inputs: I_Req, D_Req, last_owner.
  - Outputs: valid, winner.
- FSM, latches and latency counter stay in mem_port_arbiter.

Test Plan:
- Fetch only: I_Req=1, I_Addr=0x40, memory returns 0x8C220004 at READ_LAT=2 → I_Gnt cycle 1, Mem_WrEn=0 throughout, I_RValid cycle 3 with I_RData=0x8C220004, Busy low cycle 4.
- Store: D_Req=1, D_We=1, D_Addr=0x100, D_WData=0xDEADBEEF → Mem_WrEn=1 only in cycle 1 with Mem_Addr=0x100 and Mem_WData=0xDEADBEEF, D_Done cycle 2, no I_* pulses.
- Conflict after reset: both Req at cycle 0 and held → data served first (D_Gnt), fetch granted on the next IDLE. With both held again, grants alternate D, I, D, I.
- Back-to-back loads with I_Req held → data never granted twice in a row while I_Req is pending.
- Latency sweep READ_LAT=1 and 7 → valid pulse exactly at cycle 1+READ_LAT. Rdata equals Mem_RData sampled at the end of the last ACCESS cycle, not earlier values.
- Reset_n low in the second ACCESS cycle of a load → all outputs 0 immediately, no RValid/Done afterward. After release with D_Req=I_Req=1, data wins (last_owner=fetch).
